// File: rtl/add_sub_16bit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_16bit_pkg
// Description : Shared ALU constants: datapath width and add/sub op encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package add_sub_16bit_pkg;

    localparam int   DATA_W = 16;
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage : add_sub_16bit_pkg
`default_nettype wire

// File: rtl/add_sub_16bit_full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : Single-bit full-adder cell used in the ripple-carry chain.
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    logic w_p;

    assign w_p  = a ^ b;
    assign sum  = w_p ^ cin;
    assign cout = (a & b) | (cin & w_p);

endmodule : full_adder
`default_nettype wire

// File: rtl/add_sub_16bit.sv
`default_nettype none
// ============================================================================
// Module      : add_sub_16bit
// Description : Registered 16-bit adder/subtractor on one shared ripple chain,
//               with registered carry-out and signed-overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module add_sub_16bit
    import add_sub_16bit_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic              sub,
    output logic [DATA_W-1:0] s,
    output logic              cout,
    output logic              ovf
);

    logic              w_sub;
    logic [DATA_W-1:0] w_b;
    logic [DATA_W-1:0] w_sum;
    logic [DATA_W:0]   w_c;
    logic              w_ovf;

    logic [DATA_W-1:0] r_s;
    logic              r_cout;
    logic              r_ovf;

    // Subtraction is in1 + ~in2 + 1: invert B and inject the +1 as carry-in.
    assign w_sub  = (sub == OP_SUB);
    assign w_b    = in2 ^ {DATA_W{w_sub}};
    assign w_c[0] = w_sub;

    generate
        for (genvar gi = 0; gi < DATA_W; gi++) begin : g_chain
            full_adder u_fa (
                .a    (in1[gi]),
                .b    (w_b[gi]),
                .cin  (w_c[gi]),
                .sum  (w_sum[gi]),
                .cout (w_c[gi+1])
            );
        end
    endgenerate

    assign w_ovf = w_c[DATA_W] ^ w_c[DATA_W-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s    <= '0;
            r_cout <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_s    <= w_sum;
            r_cout <= w_c[DATA_W];
            r_ovf  <= w_ovf;
        end
    end

    assign s    = r_s;
    assign cout = r_cout;
    assign ovf  = r_ovf;

endmodule : add_sub_16bit
`default_nettype wire

// File: tb/tb_add_sub_16bit.sv
`default_nettype none
// ============================================================================
// Module      : tb_add_sub_16bit
// Description : Scoreboard bench for add_sub_16bit: directed and random ops.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_add_sub_16bit;

    typedef struct packed {
        logic [15:0] s;
        logic        cout;
        logic        ovf;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic        sub = 1'b0;
    logic [15:0] s;
    logic        cout;
    logic        ovf;

    int checks   = 0;
    int failures = 0;

    exp_t  q_exp[$];
    string q_name[$];

    add_sub_16bit dut (
        .clk  (clk),
        .rst  (rst),
        .in1  (in1),
        .in2  (in2),
        .sub  (sub),
        .s    (s),
        .cout (cout),
        .ovf  (ovf)
    );

    always #5 clk = ~clk;

    // Reference: integer arithmetic on unsigned and signed views of the operands.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b, input logic op);
        exp_t        r;
        int          sa;
        int          sb;
        int          sr;
        logic [16:0] u;
        sa = $signed(a);
        sb = $signed(b);
        if (op == 1'b0) begin
            u      = {1'b0, a} + {1'b0, b};
            r.s    = u[15:0];
            r.cout = u[16];
            sr     = sa + sb;
        end else begin
            r.s    = a - b;
            r.cout = (a >= b);
            sr     = sa - sb;
        end
        r.ovf = (sr > 32767) || (sr < -32768);
        return r;
    endfunction

    task automatic drive(input logic r, input logic [15:0] a, input logic [15:0] b,
                         input logic op, input exp_t e, input string nm);
        @(negedge clk);
        rst = r;
        in1 = a;
        in2 = b;
        sub = op;
        q_exp.push_back(e);
        q_name.push_back(nm);
    endtask

    // Monitor: one result per edge; compare whenever an expectation is pending.
    initial begin
        exp_t  e;
        string nm;
        forever begin
            @(posedge clk);
            #1;
            if (q_exp.size() > 0) begin
                e  = q_exp.pop_front();
                nm = q_name.pop_front();
                checks++;
                if (s !== e.s || cout !== e.cout || ovf !== e.ovf) begin
                    failures++;
                    $display("FAIL %s: got s=%h cout=%b ovf=%b, expected s=%h cout=%b ovf=%b",
                             nm, s, cout, ovf, e.s, e.cout, e.ovf);
                end
            end
        end
    end

    initial begin
        exp_t        zero;
        logic [15:0] a;
        logic [15:0] b;
        logic        op;
        zero = '{s: 16'h0000, cout: 1'b0, ovf: 1'b0};

        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, zero, "reset0");
        drive(1'b1, 16'hAAAA, 16'h5555, 1'b1, zero, "reset1");

        drive(1'b0, 16'h1234, 16'h0001, 1'b0, '{16'h1235, 1'b0, 1'b0}, "add_basic");
        drive(1'b0, 16'hFFFF, 16'h0001, 1'b0, '{16'h0000, 1'b1, 1'b0}, "add_carry");
        drive(1'b0, 16'h7FFF, 16'h0001, 1'b0, '{16'h8000, 1'b0, 1'b1}, "add_ovf_pos");
        drive(1'b0, 16'h8000, 16'h8000, 1'b0, '{16'h0000, 1'b1, 1'b1}, "add_ovf_neg");
        drive(1'b0, 16'h0005, 16'h0007, 1'b1, '{16'hFFFE, 1'b0, 1'b0}, "sub_borrow");
        drive(1'b0, 16'h8000, 16'h0001, 1'b1, '{16'h7FFF, 1'b1, 1'b1}, "sub_ovf");
        drive(1'b0, 16'h1234, 16'h1234, 1'b1, '{16'h0000, 1'b1, 1'b0}, "sub_equal");
        drive(1'b0, 16'h0000, 16'h8000, 1'b1, '{16'h8000, 1'b0, 1'b1}, "sub_min");

        for (int i = 0; i < 500; i++) begin
            a  = 16'($urandom);
            b  = 16'($urandom);
            op = 1'($urandom);
            if (i == 250)
                drive(1'b1, a, b, op, zero, "rand_reset");
            else
                drive(1'b0, a, b, op, model(a, b, op), "random");
        end

        drive(1'b0, 16'hFFFF, 16'hFFFF, 1'b0, model(16'hFFFF, 16'hFFFF, 1'b0), "add_ffff");

        repeat (3) @(negedge clk);
        checks++;
        if (q_exp.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending, expected 0", q_exp.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_add_sub_16bit
`default_nettype wire

// File: doc/add_sub_16bit.md
# add_sub_16bit

Registered 16-bit two's-complement adder/subtractor for the ALU datapath. Computes `in1 + in2` or `in1 - in2`, selected per cycle by `sub`, through one shared ripple-carry chain. Results and carry/overflow flags are registered once. The block feeds the ALU result mux and flag logic.

## Interface
Parameters:
- none (width fixed at 16)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  reset, synchronous, active-high
- `in1`  in  16  operand A (minuend when subtracting)
- `in2`  in  16  operand B (subtrahend when subtracting)
- `sub`  in  1  0 = add, 1 = subtract
- `s`  out  16  registered result, modulo 2^16
- `cout`  out  1  registered carry out of bit 15; for subtract, 1 = no borrow (`in1 >= in2` unsigned)
- `ovf`  out  1  registered signed overflow

## Operation
- B operand to the chain is `in2[i] XOR sub` for every bit; carry-in to bit 0 is `sub`. Subtraction is therefore `in1 + ~in2 + 1`.
- Chain: 16 full-adder cells, ripple-connected. Cell i takes a_i, b_i, c_i and produces sum_i and c_(i+1).
- `s_next = sum[15:0]`, with wrap-around modulo 2^16 and no saturation.
- `cout_next = c16`.
- `ovf_next = c16 XOR c15`, equivalently signed operands of equal effective sign producing a result of the opposite sign.
- Operands are treated as unsigned or two's-complement equally. Only the flags differ in interpretation.
- There is no enable and no handshake. A new operation is accepted every cycle.
- `in1 == in2` with `sub = 1` gives `s = 0`, `cout = 1`, `ovf = 0`.

## Timing
- Latency 1 cycle: inputs are sampled at rising edge N, and `s`/`cout`/`ovf` reflect them from edge N until edge N+1.
- Throughput 1 operation per cycle. Inputs may change every cycle, including `sub`.
- Reset: when `rst = 1` at a rising edge, `s = 16'h0000`, `cout = 0`, `ovf = 0` after that edge, regardless of inputs.
- Reset mid-stream: the operation sampled on a reset edge is discarded. The first non-reset edge loads the then-current inputs normally.
- Before the first clock edge, output values are undefined. The bench must apply reset first.
- The combinational path `in* → ripple chain → flops` must meet timing at the ALU clock. The ripple depth is 16 cells.

## Structure
- Sub-module `full_adder`: ports a, b, cin → sum, cout, with `sum = a^b^cin` and `cout = ab | cin(a^b)`. It is instantiated 16 times via generate, with an explicit carry vector c[16:0].
- Top level contains the B-invert XOR row, the carry chain, overflow logic, and the output register with synchronous reset.
- The shared ALU package holds `DATA_W = 16` and the op encodings `OP_ADD = 1'b0` and `OP_SUB = 1'b1`. No typedefs are needed.

## Test plan
- Reset: hold `rst = 1` for 2 cycles with `in1 = 16'hAAAA`, `in2 = 16'h5555`, `sub = 1` → `s = 0`, `cout = 0`, `ovf = 0` after each edge.
- Add basic and carry:
  - `16'h1234 + 16'h0001` → `s = 16'h1235`, `cout = 0`, `ovf = 0`.
  - `16'hFFFF + 16'h0001` → `s = 16'h0000`, `cout = 1`, `ovf = 0`.
- Signed add overflow: `16'h7FFF + 16'h0001` → `s = 16'h8000`, `cout = 0`, `ovf = 1`.
  - `16'h8000 + 16'h8000` → `s = 0`, `cout = 1`, `ovf = 1`.
- Subtract:
  - `16'h0005 - 16'h0007` → `s = 16'hFFFE`, `cout = 0`, `ovf = 0`.
  - `16'h8000 - 16'h0001` → `s = 16'h7FFF`, `cout = 1`, `ovf = 1`.
  - `16'h1234 - 16'h1234` → `s = 0`, `cout = 1`.
- Streaming random: randomize `in1`/`in2`/`sub` every cycle for 500 cycles. Each output must equal the model of the previous cycle's inputs, `(in1 ± in2) mod 2^16`, with matching flags. Assert `rst` for one cycle mid-stream → outputs are 0 on the next cycle, then normal operation resumes.
